run_sequencer: RTL and testbench
================================

# run_sequencer

Host-side initiator for the processor's Start/Ack handshake. It sits outside the processor top level, next to it. It launches a batch of programs back-to-back: for each one it pulses Start, waits for the done flag (Ack), and measures how many cycles the program took. It also provides a timeout and reports one result per program, so benches and on-board harnesses share one launch/measure engine.

## Interface
Parameters:
- NUM_PROGS, 3: programs per full batch; program indices run 0..NUM_PROGS-1.
- PIDX_W, $clog2(NUM_PROGS) (minimum 1): program index width.
- CYC_W, 16: cycle-count width.
- START_LEN, 2: cycles DutStart is held high (minimum 1).
- TIMEOUT, 2**CYC_W-1: maximum run cycles before abort.

Ports (one clock; reset is asynchronous and active-high):
- Clk  in  1  clock; posedge only.
- Reset  in  1  asynchronous, active-high reset.
- Go  in  1  batch request; sampled only in IDLE.
- FirstProg  in  PIDX_W  first program index of the batch; sampled with Go.
- DutStart  out  1  drives the processor's Start input.
- DutAck  in  1  processor done flag (level).
- Busy  out  1  high from the cycle after Go is accepted until BatchDone.
- ProgIdx  out  PIDX_W  index of the program currently running or being reported.
- ResultValid  out  1  one-cycle pulse per finished program.
- ResultCycles  out  CYC_W  measured cycles; valid with ResultValid and held until the next one.
- ResultTimeout  out  1  qualifies ResultCycles as a timeout; valid with ResultValid.
- BatchDone  out  1  one-cycle pulse when the batch ends.

## Operation
States: IDLE, START, ARM, RUN, REPORT, DONE.
- IDLE:
  - Go=1 and FirstProg<NUM_PROGS: load ProgIdx=FirstProg and go to START.
  - FirstProg>=NUM_PROGS: Go is ignored.
- START:
  - DutStart=1 for exactly START_LEN cycles, then go to ARM.
  - Cycle counter cleared.
- ARM:
  - Counter increments each cycle.
  - DutAck is ignored until it is seen low once; that cycle moves to RUN.
  - This rejects a stale Ack left high from the previous program.
- RUN:
  - Counter increments each cycle.
  - The first cycle with DutAck=1 moves to REPORT.
- Timeout: in ARM or RUN, if the count reaches TIMEOUT with no qualified Ack, go to REPORT with ResultTimeout=1.
- REPORT:
  - ResultValid=1 for one cycle; ResultCycles and ResultTimeout are latched.
  - Next state is DONE if there was a timeout or ProgIdx==NUM_PROGS-1.
  - Otherwise ProgIdx increments and the next state is START.
- DONE: BatchDone=1 for one cycle, Busy drops, return to IDLE.
- Cycle rule: ResultCycles = number of cycles from the first cycle with DutStart low through the cycle in which the qualified Ack is first high, inclusive.
  - The counter saturates at TIMEOUT and never wraps.
- A timeout aborts the rest of the batch. ProgIdx keeps the index of the program that timed out.
- Go while Busy is ignored; no queueing.
- Simultaneous cases:
  - DutAck high in the same cycle the counter reaches TIMEOUT: the Ack wins and ResultTimeout=0.
  - Go in the DONE cycle: ignored, because Go is sampled only in IDLE.

## Timing
- Reset (asynchronous, immediate, no clock edge needed) forces:
  - state IDLE;
  - DutStart, Busy, ResultValid, BatchDone, ResultTimeout = 0;
  - ProgIdx = 0, ResultCycles = 0.
- Reset mid-run aborts without a report; DutStart falls immediately.
- All outputs are registered; no combinational path from DutAck or Go to any output.
- Go accepted at edge N: Busy=1 and DutStart=1 from N+1 through N+START_LEN.
- Qualified Ack in cycle k: ResultValid in cycle k+1. DutStart for the next program rises at k+2.
- Last program: BatchDone in the cycle after its ResultValid.

## Structure
- Package run_seq_pkg holds:
  - the state enum typedef (IDLE..DONE);
  - default constants DEF_NUM_PROGS=3, DEF_CYC_W=16, DEF_START_LEN=2.
- One sub-module, run_timer: a saturating counter with clear, enable, and a reached-limit flag (CYC_W wide, limit input).
- The FSM and result registers live in run_sequencer.

## Test plan
- Reset asserted between edges: all outputs go to their reset values immediately; DutStart stays 0 with Go toggling during reset.
- Full batch: FirstProg=0, DUT model acks 10, 20, 30 cycles after Start falls. Required response:
  - three ResultValid pulses with ResultCycles 10, 20, 30;
  - ProgIdx 0, 1, 2;
  - ResultTimeout=0;
  - BatchDone one cycle after the third report.
- Stale Ack: DutAck held high through START and 3 ARM cycles, low, then high in cycle 8 -> ResultCycles=8 (not 1).
- Timeout: TIMEOUT=50, DUT never acks -> ResultValid with ResultTimeout=1, ResultCycles=50, ProgIdx=0, BatchDone next cycle, no further DutStart.
- Ignored requests:
  - FirstProg=3 with NUM_PROGS=3 -> stays IDLE, Busy=0.
  - Go pulsed while Busy -> no extra programs.
  - Ack arriving in the same cycle the count reaches TIMEOUT -> ResultTimeout=0.
- Reset asserted mid-RUN on program 1: DutStart and Busy drop without a clock edge, no ResultValid, and the next Go restarts cleanly from FirstProg.

Source files
------------

// File: rtl/run_seq_pkg.sv
// Shared types and default constants for the run_sequencer launch/measure engine.
package run_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    ARM,
    RUN,
    REPORT,
    DONE
  } state_t;

  localparam int DEF_NUM_PROGS = 3;
  localparam int DEF_CYC_W     = 16;
  localparam int DEF_START_LEN = 2;

endpackage

// File: rtl/run_timer.sv
// Saturating cycle counter with synchronous clear, count enable and a reached-limit flag.
module run_timer
  import run_seq_pkg::*;
#(
  parameter int CYC_W = DEF_CYC_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  input  logic [CYC_W-1:0] limit,
  output logic [CYC_W-1:0] count,
  output logic             reached
);

  // NOTE: sequential state is always written with <= so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != limit)) begin
      count <= count + CYC_W'(1);
    end
  end

  assign reached = (count >= limit);

endmodule

// File: rtl/run_sequencer.sv
// Launches a batch of programs over the Start/Ack handshake, measures each run and reports one result per program.
module run_sequencer
  import run_seq_pkg::*;
#(
  parameter int NUM_PROGS = DEF_NUM_PROGS,
  parameter int PIDX_W    = (NUM_PROGS > 1) ? $clog2(NUM_PROGS) : 1,
  parameter int CYC_W     = DEF_CYC_W,
  parameter int START_LEN = DEF_START_LEN,
  parameter int TIMEOUT   = 2**CYC_W - 1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Go,
  input  logic [PIDX_W-1:0] FirstProg,
  output logic              DutStart,
  input  logic              DutAck,
  output logic              Busy,
  output logic [PIDX_W-1:0] ProgIdx,
  output logic              ResultValid,
  output logic [CYC_W-1:0]  ResultCycles,
  output logic              ResultTimeout,
  output logic              BatchDone
);

  localparam int                SC_W        = (START_LEN > 1) ? $clog2(START_LEN) : 1;
  localparam logic [SC_W-1:0]   START_LAST  = SC_W'(START_LEN - 1);
  localparam logic [PIDX_W:0]   NUM_PROGS_X = (PIDX_W + 1)'(NUM_PROGS);
  localparam logic [PIDX_W-1:0] LAST_IDX    = PIDX_W'(NUM_PROGS - 1);
  localparam logic [CYC_W-1:0]  LIMIT       = CYC_W'(TIMEOUT);

  state_t            state, next_state;
  logic [SC_W-1:0]   start_cnt;
  logic [CYC_W-1:0]  count;
  logic              reached;
  logic              timeout_hit;
  logic              go_ok;

  assign go_ok = Go && ({1'b0, FirstProg} < NUM_PROGS_X);

  // Counter restarts while Start is driven, so the first Start-low cycle reads as 1.
  run_timer #(.CYC_W(CYC_W)) u_timer (
    .clk     (Clk),
    .rst     (Reset),
    .clear   (next_state == START),
    .enable  ((next_state == ARM) || (next_state == RUN)),
    .limit   (LIMIT),
    .count   (count),
    .reached (reached)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      start_cnt <= '0;
    end else begin
      state     <= next_state;
      start_cnt <= (state == START) ? start_cnt + SC_W'(1) : '0;
    end
  end

  // NOTE: every variable driven here gets a default first, so no path can infer a latch.
  always_comb begin
    next_state  = state;
    timeout_hit = 1'b0;
    case (state)
      IDLE:   if (go_ok) next_state = START;
      START:  if (start_cnt == START_LAST) next_state = ARM;
      ARM: begin
        if (reached) begin
          next_state  = REPORT;
          timeout_hit = 1'b1;
        end else if (!DutAck) begin
          next_state = RUN;
        end
      end
      RUN: begin
        // A qualified Ack beats a simultaneous timeout.
        if (DutAck) begin
          next_state = REPORT;
        end else if (reached) begin
          next_state  = REPORT;
          timeout_hit = 1'b1;
        end
      end
      REPORT: next_state = (ResultTimeout || (ProgIdx == LAST_IDX)) ? DONE : START;
      DONE:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Outputs are decoded from next_state into flops so none has a combinational path from Go or DutAck.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      DutStart      <= 1'b0;
      Busy          <= 1'b0;
      ResultValid   <= 1'b0;
      BatchDone     <= 1'b0;
      ResultTimeout <= 1'b0;
      ResultCycles  <= '0;
      ProgIdx       <= '0;
    end else begin
      DutStart    <= (next_state == START);
      Busy        <= (next_state == START) || (next_state == ARM) ||
                     (next_state == RUN)   || (next_state == REPORT);
      ResultValid <= (next_state == REPORT);
      BatchDone   <= (next_state == DONE);
      if (next_state == REPORT) begin
        ResultCycles  <= count;
        ResultTimeout <= timeout_hit;
      end
      if ((state == IDLE) && go_ok) begin
        ProgIdx <= FirstProg;
      end else if ((state == REPORT) && (next_state == START)) begin
        ProgIdx <= ProgIdx + PIDX_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_run_sequencer.sv
// Directed bench for run_sequencer: a scoreboard queue of expected reports checked against every ResultValid pulse.
module tb_run_sequencer;

  localparam int NUM_PROGS = 3;
  localparam int PIDX_W    = 2;
  localparam int CYC_W     = 16;
  localparam int START_LEN = 2;
  localparam int TIMEOUT   = 50;

  logic              Clk = 1'b0;
  logic              Reset = 1'b0;
  logic              Go = 1'b0;
  logic [PIDX_W-1:0] FirstProg = '0;
  logic              DutStart;
  logic              DutAck = 1'b0;
  logic              Busy;
  logic [PIDX_W-1:0] ProgIdx;
  logic              ResultValid;
  logic [CYC_W-1:0]  ResultCycles;
  logic              ResultTimeout;
  logic              BatchDone;

  typedef struct {
    logic [PIDX_W-1:0] idx;
    logic [CYC_W-1:0]  cycles;
    logic              to;
    bit                last;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   exp_done = 1'b0;

  run_sequencer #(
    .NUM_PROGS(NUM_PROGS),
    .PIDX_W   (PIDX_W),
    .CYC_W    (CYC_W),
    .START_LEN(START_LEN),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .Go           (Go),
    .FirstProg    (FirstProg),
    .DutStart     (DutStart),
    .DutAck       (DutAck),
    .Busy         (Busy),
    .ProgIdx      (ProgIdx),
    .ResultValid  (ResultValid),
    .ResultCycles (ResultCycles),
    .ResultTimeout(ResultTimeout),
    .BatchDone    (BatchDone)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push(input int idx, input int cyc, input bit to, input bit last);
    exp_t e;
    e.idx    = PIDX_W'(idx);
    e.cycles = CYC_W'(cyc);
    e.to     = to;
    e.last   = last;
    sb.push_back(e);
  endtask

  // Scoreboard side: each report pops one expectation; BatchDone must follow the last one.
  always @(negedge Clk) begin
    exp_t e;
    if (!Reset) begin
      if (BatchDone || exp_done) check("batch_done", 32'(BatchDone), 32'(exp_done));
      exp_done = 1'b0;
      if (ResultValid) begin
        if (sb.size() == 0) begin
          check("result_valid_spurious", 32'(ResultValid), 32'd0);
        end else begin
          e = sb.pop_front();
          check("result_idx", 32'(ProgIdx), 32'(e.idx));
          check("result_cycles", 32'(ResultCycles), 32'(e.cycles));
          check("result_timeout", 32'(ResultTimeout), 32'(e.to));
          exp_done = e.last;
        end
      end
    end
  end

  // Processor model for one program: acks n cycles after Start falls (n >= 2).
  task automatic run_prog(input int n, input int idx, input bit pulse_go, input bit do_ack);
    bit ok;
    int hi;
    int c;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (DutStart) begin
        ok = 1'b1;
        break;
      end
      @(negedge Clk);
    end
    check("start_rise", 32'(ok), 32'd1);
    if (!ok) return;
    DutAck = 1'b0;
    hi = 1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk);
      if (!DutStart) begin
        ok = 1'b1;
        break;
      end
      hi++;
    end
    check("start_fall", 32'(ok), 32'd1);
    check("start_len", 32'(hi), 32'(START_LEN));
    check("prog_idx_run", 32'(ProgIdx), 32'(idx));
    check("busy_run", 32'(Busy), 32'd1);
    c = 1;
    while (c < n) begin
      @(negedge Clk);
      c++;
      Go = (pulse_go && (c == 3));
    end
    Go = 1'b0;
    if (do_ack) DutAck = 1'b1;
  endtask

  task automatic launch(input int first);
    FirstProg = PIDX_W'(first);
    Go = 1'b1;
    @(negedge Clk);
    Go = 1'b0;
    check("go_busy", 32'(Busy), 32'd1);
    check("go_start", 32'(DutStart), 32'd1);
  endtask

  task automatic wait_drain(input int max_cycles);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge Clk);
      if (sb.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    check("drained", 32'(ok), 32'd1);
    repeat (2) @(negedge Clk);
    check("idle_busy", 32'(Busy), 32'd0);
    DutAck = 1'b0;
  endtask

  task automatic check_no_restart(input string tag);
    bit saw;
    saw = 1'b0;
    repeat (10) begin
      @(negedge Clk);
      if (DutStart || Busy) saw = 1'b1;
    end
    check(tag, 32'(saw), 32'd0);
  endtask

  initial begin
    int c;
    bit ok;

    // Asynchronous reset between edges.
    #2 Reset = 1'b1;
    #1;
    check("rst_dut_start", 32'(DutStart), 32'd0);
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_result_valid", 32'(ResultValid), 32'd0);
    check("rst_batch_done", 32'(BatchDone), 32'd0);
    check("rst_result_timeout", 32'(ResultTimeout), 32'd0);
    check("rst_prog_idx", 32'(ProgIdx), 32'd0);
    check("rst_result_cycles", 32'(ResultCycles), 32'd0);
    repeat (4) begin
      @(negedge Clk);
      Go = ~Go;
      @(negedge Clk);
      check("rst_go_toggle_start", 32'(DutStart), 32'd0);
    end
    @(negedge Clk);
    Go = 1'b0;
    Reset = 1'b0;
    @(negedge Clk);

    // Out-of-range FirstProg is ignored.
    FirstProg = 2'd3;
    Go = 1'b1;
    repeat (2) @(negedge Clk);
    Go = 1'b0;
    @(negedge Clk);
    check("bad_first_busy", 32'(Busy), 32'd0);
    check("bad_first_start", 32'(DutStart), 32'd0);

    // Full batch, with a Go pulse while busy that must be ignored.
    push(0, 10, 1'b0, 1'b0);
    push(1, 20, 1'b0, 1'b0);
    push(2, 30, 1'b0, 1'b1);
    launch(0);
    run_prog(10, 0, 1'b0, 1'b1);
    run_prog(20, 1, 1'b1, 1'b1);
    run_prog(30, 2, 1'b0, 1'b1);
    wait_drain(50);
    check_no_restart("batch_no_extra");

    // Stale Ack held high through START and three ARM cycles.
    push(2, 8, 1'b0, 1'b1);
    DutAck = 1'b1;
    launch(2);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk);
      if (!DutStart) begin
        ok = 1'b1;
        break;
      end
    end
    check("stale_start_fall", 32'(ok), 32'd1);
    c = 1;
    while (c < 8) begin
      @(negedge Clk);
      c++;
      if (c == 4) DutAck = 1'b0;
      if (c == 8) DutAck = 1'b1;
    end
    wait_drain(20);

    // Timeout: no Ack at all aborts the rest of the batch.
    push(0, TIMEOUT, 1'b1, 1'b1);
    launch(0);
    wait_drain(TIMEOUT + 20);
    check("timeout_prog_idx_held", 32'(ProgIdx), 32'd0);
    check_no_restart("timeout_no_restart");

    // Ack in the very cycle the count reaches TIMEOUT wins.
    push(2, TIMEOUT, 1'b0, 1'b1);
    launch(2);
    run_prog(TIMEOUT, 2, 1'b0, 1'b1);
    wait_drain(20);

    // Reset mid-RUN on program 1, then a clean restart from FirstProg=1.
    push(0, 5, 1'b0, 1'b0);
    launch(0);
    run_prog(5, 0, 1'b0, 1'b1);
    run_prog(6, 1, 1'b0, 1'b0);
    #2 Reset = 1'b1;
    #1;
    check("midrst_busy", 32'(Busy), 32'd0);
    check("midrst_start", 32'(DutStart), 32'd0);
    check("midrst_valid", 32'(ResultValid), 32'd0);
    check("midrst_prog_idx", 32'(ProgIdx), 32'd0);
    check("midrst_cycles", 32'(ResultCycles), 32'd0);
    @(negedge Clk);
    Reset = 1'b0;
    DutAck = 1'b0;
    repeat (3) @(negedge Clk);
    check("midrst_idle", 32'(Busy), 32'd0);
    push(1, 7, 1'b0, 1'b0);
    push(2, 3, 1'b0, 1'b1);
    launch(1);
    run_prog(7, 1, 1'b0, 1'b1);
    run_prog(3, 2, 1'b0, 1'b1);
    wait_drain(20);

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of test, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
